// File: rtl/enemy_wave_ctrl.sv
// Enemy wave controller. It spawns four enemies one at a time, tracks which are alive,
// advances the level after each cleared wave, and assigns a random direction to one enemy per frame.
module enemy_wave_ctrl #(
    parameter int SPAWN_GAP_FRAMES = 30,
    parameter int CLEAR_FRAMES     = 60,
    parameter int MAX_LEVEL        = 15
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        startGame,
    input  logic [3:0]  enemyHit,
    input  logic [7:0]  random_in,
    output logic [3:0]  enemyEnable,
    output logic [3:0]  enemyResetN,
    output logic [11:0] randomDir,
    output logic [2:0]  enemiesLeft,
    output logic [3:0]  level,
    output logic        waveClear
);

    localparam int CNT_MAX = (SPAWN_GAP_FRAMES > CLEAR_FRAMES) ? SPAWN_GAP_FRAMES : CLEAR_FRAMES;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 8) ? $clog2(CNT_MAX + 1) : 8;
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(SPAWN_GAP_FRAMES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_FRAMES - 1);
    localparam logic [3:0]       LEVEL_MAX  = 4'(MAX_LEVEL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        RUN   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t           state_reg;
    logic [1:0]       spawn_idx_reg;
    logic             first_spawn_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic [1:0]       dir_ptr_reg;

    logic             spawn_now;
    logic [3:0]       spawn_mask;
    logic [3:0]       enable_next;
    logic [3:0]       reload_next;
    logic [11:0]      dir_next;

    // The first enemy of a wave appears on the first SPAWN cycle; later ones wait out the gap.
    assign spawn_now = (state_reg == SPAWN) && !startGame &&
                       (first_spawn_reg || (startOfFrame && (frame_cnt_reg == GAP_LAST)));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_enemy
            assign spawn_mask[gi]  = spawn_now && (spawn_idx_reg == 2'(gi));
            // A spawn overrides a simultaneous hit; a restart clears everything.
            assign enable_next[gi] = startGame ? 1'b0
                                   : (spawn_mask[gi] | (enemyEnable[gi] & ~enemyHit[gi]));
            assign reload_next[gi] = ~spawn_mask[gi];
            assign dir_next[3*gi +: 3] = (startOfFrame && (dir_ptr_reg == 2'(gi)))
                                       ? ({1'b0, random_in[1:0]} + 3'd1)
                                       : randomDir[3*gi +: 3];
        end
    endgenerate

    assign enemiesLeft = {2'b00, enemyEnable[0]} + {2'b00, enemyEnable[1]}
                       + {2'b00, enemyEnable[2]} + {2'b00, enemyEnable[3]};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            enemyEnable <= 4'b0000;
            enemyResetN <= 4'b1111;
            randomDir   <= {4{3'd1}};
            dir_ptr_reg <= 2'd0;
        end else begin
            enemyEnable <= enable_next;
            enemyResetN <= reload_next;
            randomDir   <= dir_next;
            if (startOfFrame) begin
                dir_ptr_reg <= dir_ptr_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg       <= IDLE;
            spawn_idx_reg   <= 2'd0;
            first_spawn_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            level           <= 4'd1;
            waveClear       <= 1'b0;
        end else if (startGame) begin
            state_reg       <= SPAWN;
            spawn_idx_reg   <= 2'd0;
            first_spawn_reg <= 1'b1;
            frame_cnt_reg   <= '0;
            level           <= 4'd1;
            waveClear       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    level <= 4'd1;
                end
                SPAWN: begin
                    first_spawn_reg <= 1'b0;
                    if (spawn_now) begin
                        spawn_idx_reg <= spawn_idx_reg + 2'd1;
                        frame_cnt_reg <= '0;
                        if (spawn_idx_reg == 2'd3) begin
                            state_reg <= RUN;
                        end
                    end else if (startOfFrame) begin
                        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (enemyEnable == 4'b0000) begin
                        state_reg     <= CLEAR;
                        frame_cnt_reg <= '0;
                        waveClear     <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (startOfFrame) begin
                        if (frame_cnt_reg == CLEAR_LAST) begin
                            state_reg       <= SPAWN;
                            spawn_idx_reg   <= 2'd0;
                            first_spawn_reg <= 1'b1;
                            frame_cnt_reg   <= '0;
                            waveClear       <= 1'b0;
                            if (level < LEVEL_MAX) begin
                                level <= level + 4'd1;
                            end
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Directed bench for enemy_wave_ctrl: reset, direction scheduler, spawning, hits,
// wave clear, level saturation and restart.
module tb_enemy_wave_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        startGame;
    logic [3:0]  enemyHit;
    logic [7:0]  random_in;
    logic [3:0]  enemyEnable;
    logic [3:0]  enemyResetN;
    logic [11:0] randomDir;
    logic [2:0]  enemiesLeft;
    logic [3:0]  level;
    logic        waveClear;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    enemy_wave_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startGame    (startGame),
        .enemyHit     (enemyHit),
        .random_in    (random_in),
        .enemyEnable  (enemyEnable),
        .enemyResetN  (enemyResetN),
        .randomDir    (randomDir),
        .enemiesLeft  (enemiesLeft),
        .level        (level),
        .waveClear    (waveClear)
    );

    typedef struct {
        logic [3:0] hit;
        logic       sof;
        logic [3:0] exp_en;
        logic [2:0] exp_left;
        logic       exp_wc;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    logic [11:0] exp_dir;
    logic [3:0]  exp_level;

    initial begin
        tbl[0] = '{hit: 4'b0101, sof: 1'b0, exp_en: 4'b1010, exp_left: 3'd2, exp_wc: 1'b0};
        tbl[1] = '{hit: 4'b0000, sof: 1'b0, exp_en: 4'b1010, exp_left: 3'd2, exp_wc: 1'b0};
        tbl[2] = '{hit: 4'b0101, sof: 1'b0, exp_en: 4'b1010, exp_left: 3'd2, exp_wc: 1'b0};
        tbl[3] = '{hit: 4'b1010, sof: 1'b0, exp_en: 4'b0000, exp_left: 3'd0, exp_wc: 1'b0};
        tbl[4] = '{hit: 4'b0000, sof: 1'b0, exp_en: 4'b0000, exp_left: 3'd0, exp_wc: 1'b1};
        tbl[5] = '{hit: 4'b0000, sof: 1'b1, exp_en: 4'b0000, exp_left: 3'd0, exp_wc: 1'b1};
        tbl[6] = '{hit: 4'b0001, sof: 1'b0, exp_en: 4'b0000, exp_left: 3'd0, exp_wc: 1'b1};

        resetN = 1'b0; startOfFrame = 1'b0; startGame = 1'b0;
        enemyHit = 4'b0; random_in = 8'h00;
        tick(); tick();
        check("rst_enable", 32'(enemyEnable), 32'h0);
        check("rst_reload", 32'(enemyResetN), 32'hF);
        check("rst_dir", 32'(randomDir), 32'h249);
        check("rst_level", 32'(level), 32'd1);
        check("rst_clear", 32'(waveClear), 32'd0);
        check("rst_left", 32'(enemiesLeft), 32'd0);
        resetN = 1'b1;
        tick();
        check("release_enable", 32'(enemyEnable), 32'h0);
        check("release_reload", 32'(enemyResetN), 32'hF);

        // Direction scheduler: one field per frame, in order 0..3.
        exp_dir = 12'h249;
        random_in = 8'hFF;
        for (int f = 0; f < 4; f++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            exp_dir[3*f +: 3] = 3'd4;
            check($sformatf("dir_frame%0d", f), 32'(randomDir), 32'(exp_dir));
            tick();
        end
        random_in = 8'h02;
        frames(1);
        exp_dir[2:0] = 3'd3;
        check("dir_wrap", 32'(randomDir), 32'(exp_dir));
        random_in = 8'h00;

        // Start the game and walk through the four spawns.
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        check("start_enable", 32'(enemyEnable), 32'h0);
        tick();
        check("spawn0_enable", 32'(enemyEnable), 32'h1);
        check("spawn0_reload", 32'(enemyResetN), 32'hE);
        tick();
        check("spawn0_reload_end", 32'(enemyResetN), 32'hF);
        frames(29);
        check("gap29_enable", 32'(enemyEnable), 32'h1);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("spawn1_enable", 32'(enemyEnable), 32'h3);
        check("spawn1_reload", 32'(enemyResetN), 32'hD);
        tick();
        frames(30);
        check("spawn2_enable", 32'(enemyEnable), 32'h7);
        frames(30);
        check("spawn3_enable", 32'(enemyEnable), 32'hF);
        check("spawn3_left", 32'(enemiesLeft), 32'd4);
        frames(40);
        check("run_no_spawn", 32'(enemyResetN), 32'hF);
        check("run_noclear", 32'(waveClear), 32'd0);

        // Hits in RUN and the entry into CLEAR.
        for (int i = 0; i < 7; i++) begin
            enemyHit = tbl[i].hit;
            startOfFrame = tbl[i].sof;
            tick();
            enemyHit = 4'b0;
            startOfFrame = 1'b0;
            check($sformatf("vec%0d_enable", i), 32'(enemyEnable), 32'(tbl[i].exp_en));
            check($sformatf("vec%0d_left", i), 32'(enemiesLeft), 32'(tbl[i].exp_left));
            check($sformatf("vec%0d_clear", i), 32'(waveClear), 32'(tbl[i].exp_wc));
        end
        frames(58);
        check("clear59_wc", 32'(waveClear), 32'd1);
        check("clear59_level", 32'(level), 32'd1);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("clear60_wc", 32'(waveClear), 32'd0);
        check("clear60_level", 32'(level), 32'd2);
        tick();
        check("wave2_spawn0", 32'(enemyEnable), 32'h1);
        check("wave2_reload", 32'(enemyResetN), 32'hE);
        tick();

        // Hit coinciding with the spawn of the same enemy.
        frames(29);
        startOfFrame = 1'b1;
        enemyHit = 4'b0010;
        tick();
        startOfFrame = 1'b0;
        enemyHit = 4'b0;
        check("hit_vs_spawn", 32'(enemyEnable), 32'h3);
        tick();

        // Kill everything mid-spawn: spawning continues.
        enemyHit = 4'b0011;
        tick();
        enemyHit = 4'b0;
        check("spawn_killall", 32'(enemyEnable), 32'h0);
        frames(30);
        check("spawn_continues", 32'(enemyEnable), 32'h4);
        frames(30);
        check("spawn_last", 32'(enemyEnable), 32'hC);

        // Restart from RUN.
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        check("restart_enable", 32'(enemyEnable), 32'h0);
        check("restart_level", 32'(level), 32'd1);
        tick();
        check("restart_spawn0", 32'(enemyEnable), 32'h1);
        tick();

        // Clear waves until the level saturates.
        exp_level = 4'd1;
        for (int w = 0; w < 15; w++) begin
            frames(90);
            enemyHit = 4'b1111;
            tick();
            enemyHit = 4'b0;
            tick();
            frames(60);
            tick();
            if (exp_level < 4'd15) exp_level = exp_level + 4'd1;
            check($sformatf("wave%0d_level", w), 32'(level), 32'(exp_level));
        end
        check("sat_spawn0", 32'(enemyEnable), 32'h1);
        check("sat_clear", 32'(waveClear), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
